fetch_decode_stage: RTL and testbench
=====================================

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program counter and instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 9, meaning instruction word width.
REQ-003 SHALL have parameter START_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr  output  PC_W  instruction memory address, equal to the current PC.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port imem_ack  input  1  instruction memory response valid; imem_data is valid in the same cycle.
REQ-009 SHALL have port imem_data  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port stall  input  1  downstream (register file / execute) cannot accept a decoded instruction.
REQ-011 SHALL have port branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-012 SHALL have port branch_target  input  PC_W  redirect address.
REQ-013 SHALL have port reg1, reg2, reg_write  output  3 each  register-file read and write addresses.
REQ-014 SHALL have port reg_we  output  1  writeback enable for reg_write.
REQ-015 SHALL have port alu_op  output  2  ALU operation select.
REQ-016 SHALL have port imm  output  3  immediate or branch offset field.
REQ-017 SHALL have port is_load, is_store, is_branch  output  1 each  instruction class flags.
REQ-018 SHALL have port dec_valid  output  1  decoded fields valid.
REQ-019 SHALL have port halted  output  1  processor halted.

Function
REQ-020 SHALL implement the FSM states FETCH, WAIT, ISSUE and HALT.
REQ-021 FETCH SHALL assert imem_req for one cycle and then go to WAIT.
REQ-022 WAIT SHALL hold imem_req low; on imem_ack it SHALL register the decoded fields, increment the PC (PC_W bits, wrapping from all-ones to 0) and go to ISSUE.
REQ-023 ISSUE SHALL hold dec_valid high with stable fields until a cycle with stall=0 (accept); on accept it SHALL go to FETCH, or to HALT if the instruction is HALT.
REQ-024 HALT SHALL hold halted=1, dec_valid=0 and imem_req=0 until reset.
REQ-025 Decoding SHALL use opcode=instr[8:6], a=instr[5:3] and b=instr[2:0].
REQ-026 Opcodes 000 ADD, 001 SUB, 010 AND and 011 XOR SHALL drive reg_write=a, reg1=a, reg2=b, reg_we=1 and alu_op=opcode[1:0].
REQ-027 Opcode 100 LDI SHALL drive reg_write=a, imm=b and reg_we=1.
REQ-028 Opcode 101 LW SHALL drive reg_write=a, reg1=b, reg_we=1 and is_load=1.
REQ-029 Opcode 110 SW SHALL drive reg1=b, reg2=a, reg_we=0 and is_store=1.
REQ-030 Opcode 111 with b!=111 SHALL be BRZ: reg1=a, imm=b, is_branch=1, reg_we=0.
REQ-031 Opcode 111 with b=111 SHALL be HALT: reg_we=0 and all flags 0.
REQ-032 A write with reg_write=0 SHALL force reg_we=0, because register 0 is never written.
REQ-033 Outputs not used by the decoded opcode SHALL be 0.
REQ-034 branch_taken SHALL load PC<=branch_target on the next edge and send the FSM to FETCH from any non-HALT state.
REQ-035 A branch_taken during WAIT SHALL flush the fetch: the FSM SHALL enter a DROP sub-condition and discard the next imem_ack.
REQ-036 A branch_taken during ISSUE SHALL drop the pending instruction: dec_valid falls on the next cycle.
REQ-037 If branch_taken and an accept occur in the same cycle, the branch SHALL win; the accepted instruction counts as issued, but the PC takes branch_target.
REQ-038 branch_taken in HALT SHALL be ignored.
REQ-039 imem_ack outside WAIT SHALL be ignored.
REQ-040 Minimum issue latency SHALL be 3 cycles from FETCH entry to dec_valid when imem_ack returns one cycle after the request.

Reset
REQ-041 On reset=0, asynchronously: PC=START_PC, state=FETCH, drop flag cleared, and all outputs 0 except imem_addr=START_PC.
REQ-042 A reset asserted mid-fetch or mid-issue SHALL discard the in-flight instruction with no output glitch after release.
REQ-043 The first imem_req SHALL occur in the first clock cycle after reset deasserts.

Structure
REQ-044 A shared package SHALL hold the opcode enumeration, the FSM state enumeration, the ALU op encodings and the HALT encoding constant.
REQ-045 The design SHALL contain one combinational sub-module, instr_decoder, that maps an instruction word to the decoded fields; the FSM and PC SHALL live in fetch_decode_stage.

Verification
REQ-046 Release reset, ack 9'b000_001_010 one cycle after the request -> dec_valid at cycle 3, reg_write=1, reg1=1, reg2=2, reg_we=1, alu_op=00, and the PC becomes 1.
REQ-047 Hold stall=1 for 4 cycles during ISSUE -> fields stable and dec_valid=1 throughout; the next imem_req comes one cycle after stall falls.
REQ-048 Pulse branch_taken with target 8'h40 during WAIT, then a late ack -> the ack is discarded, the next imem_addr is 8'h40, and no dec_valid appears for the old instruction.
REQ-049 Set the PC to 8'hFF, fetch, and accept -> the PC wraps to 8'h00.
REQ-050 Fetch 9'b111_000_111 and accept -> halted=1 and imem_req stays 0 for 20 cycles, including a branch_taken pulse.
REQ-051 Decode ADD with a=000 -> reg_we=0; decode SW 9'b110_011_100 -> reg1=4, reg2=3, is_store=1; assert reset mid-WAIT -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// fetch_decode_stage_pkg: opcode/state enums, ALU encodings and HALT encoding shared by the fetch/decode slice
package fetch_decode_stage_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LDI = 3'b100,
    OP_LW  = 3'b101,
    OP_SW  = 3'b110,
    OP_BRZ = 3'b111
  } opcode_e;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  // HALT shares the BRZ opcode; b=111 is what distinguishes it
  localparam logic [8:0] HALT_INSTR = 9'b111_000_111;
  typedef struct packed {
    logic [2:0] reg1;
    logic [2:0] reg2;
    logic [2:0] reg_write;
    logic       reg_we;
    logic [1:0] alu_op;
    logic [2:0] imm;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_halt;
  } dec_t;
  function automatic logic [1:0] alu_of(logic [2:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_XOR;
  endfunction
  function automatic logic is_halt_instr(logic [8:0] i);
    return i[8:6] == HALT_INSTR[8:6] && i[2:0] == HALT_INSTR[2:0];
  endfunction
endpackage

// File: rtl/fetch_decode_stage_instr_decoder.sv
// instr_decoder: combinational map from a 9-bit instruction word to register/ALU/class fields
module instr_decoder
  import fetch_decode_stage_pkg::*;
(
  input  logic [8:0] instr,
  output logic [2:0] reg1,
  output logic [2:0] reg2,
  output logic [2:0] reg_write,
  output logic       reg_we,
  output logic [1:0] alu_op,
  output logic [2:0] imm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt
);
  opcode_e op;
  logic [2:0] a, b;
  assign op = opcode_e'(instr[8:6]);
  assign a = instr[5:3];
  assign b = instr[2:0];
  always_comb begin
    reg1 = '0;
    reg2 = '0;
    reg_write = '0;
    alu_op = '0;
    imm = '0;
    is_load = 1'b0;
    is_store = 1'b0;
    is_branch = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
        reg_write = a;
        reg1 = a;
        reg2 = b;
        alu_op = alu_of(op);
      end
      OP_LDI: begin
        reg_write = a;
        imm = b;
      end
      OP_LW: begin
        reg_write = a;
        reg1 = b;
        is_load = 1'b1;
      end
      OP_SW: begin
        reg1 = b;
        reg2 = a;
        is_store = 1'b1;
      end
      OP_BRZ: begin
        is_halt = is_halt_instr(instr);
        reg1 = is_halt ? 3'd0 : a;
        imm = is_halt ? 3'd0 : b;
        is_branch = !is_halt;
      end
    endcase
  end
  // r0 is hardwired: a write targeting it is suppressed, and non-writing ops leave reg_write at 0
  assign reg_we = reg_write != 3'd0;
endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC + fetch/wait/issue/halt FSM with branch redirect and late-ack flush
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 9,
  parameter int START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [2:0]         reg1,
  output logic [2:0]         reg2,
  output logic [2:0]         reg_write,
  output logic               reg_we,
  output logic [1:0]         alu_op,
  output logic [2:0]         imm,
  output logic               is_load,
  output logic               is_store,
  output logic               is_branch,
  output logic               dec_valid,
  output logic               halted
);
  state_e state, state_nx;
  logic [PC_W-1:0] pc;
  logic drop, ack_ok, redirect, issuing;
  logic [2:0] d_reg1, d_reg2, d_reg_write, d_imm;
  logic [1:0] d_alu_op;
  logic d_reg_we, d_is_load, d_is_store, d_is_branch, d_is_halt;
  dec_t dec_q;
  instr_decoder u_dec (
    .instr    (imem_data[8:0]),
    .reg1     (d_reg1),
    .reg2     (d_reg2),
    .reg_write(d_reg_write),
    .reg_we   (d_reg_we),
    .alu_op   (d_alu_op),
    .imm      (d_imm),
    .is_load  (d_is_load),
    .is_store (d_is_store),
    .is_branch(d_is_branch),
    .is_halt  (d_is_halt)
  );
  assign redirect = branch_taken && state != S_HALT;
  assign ack_ok = state == S_WAIT && imem_ack && !drop && !branch_taken;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  state_nx = ack_ok ? S_ISSUE : S_WAIT;
      S_ISSUE: state_nx = stall ? S_ISSUE : dec_q.is_halt ? S_HALT : S_FETCH;
      S_HALT:  state_nx = S_HALT;
    endcase
    if (redirect) state_nx = S_FETCH;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= PC_W'(START_PC);
    else if (redirect) pc <= branch_target;
    else if (ack_ok) pc <= pc + 1'b1;
  // A redirect in WAIT leaves the old request outstanding unless its ack lands in the same cycle;
  // the next ack seen afterwards belongs to that stale request and is swallowed.
  always_ff @(posedge clk or negedge reset)
    if (!reset) drop <= 1'b0;
    else if (branch_taken && state == S_WAIT) drop <= drop || !imem_ack;
    else if (imem_ack) drop <= 1'b0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) dec_q <= '0;
    else if (ack_ok) dec_q <= '{d_reg1, d_reg2, d_reg_write, d_reg_we, d_alu_op, d_imm,
                               d_is_load, d_is_store, d_is_branch, d_is_halt};
  assign issuing = state == S_ISSUE;
  // Request is gated by the reset pin so it stays low while reset is held and rises right after release
  always_comb begin
    imem_addr = pc;
    imem_req = reset && state == S_FETCH;
    dec_valid = issuing;
    halted = state == S_HALT;
    reg1 = issuing ? dec_q.reg1 : '0;
    reg2 = issuing ? dec_q.reg2 : '0;
    reg_write = issuing ? dec_q.reg_write : '0;
    reg_we = issuing && dec_q.reg_we;
    alu_op = issuing ? dec_q.alu_op : '0;
    imm = issuing ? dec_q.imm : '0;
    is_load = issuing && dec_q.is_load;
    is_store = issuing && dec_q.is_store;
    is_branch = issuing && dec_q.is_branch;
  end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed stimulus, transaction-level reference model checked every cycle
module tb_fetch_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic imem_ack = 1'b0;
  logic [8:0] imem_data = '0;
  logic stall = 1'b0;
  logic branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic [7:0] imem_addr;
  logic imem_req, reg_we, is_load, is_store, is_branch, dec_valid, halted;
  logic [2:0] reg1, reg2, reg_write, imm;
  logic [1:0] alu_op;
  int checks = 0;
  int errors = 0;

  fetch_decode_stage #(.PC_W(8), .INSTR_W(9), .START_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .reg1(reg1), .reg2(reg2), .reg_write(reg_write), .reg_we(reg_we),
    .alu_op(alu_op), .imm(imm), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .dec_valid(dec_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] rw;
    logic       we;
    logic [1:0] alu;
    logic [2:0] imm;
    logic       ld;
    logic       st;
    logic       br;
  } fields_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fields_t ref_decode(logic [8:0] w);
    fields_t f;
    int op, a, b;
    f = '0;
    op = int'(w[8:6]);
    a = int'(w[5:3]);
    b = int'(w[2:0]);
    if (op < 4) begin
      f.rw = 3'(a); f.r1 = 3'(a); f.r2 = 3'(b); f.alu = 2'(op);
    end else if (op == 4) begin
      f.rw = 3'(a); f.imm = 3'(b);
    end else if (op == 5) begin
      f.rw = 3'(a); f.r1 = 3'(b); f.ld = 1'b1;
    end else if (op == 6) begin
      f.r1 = 3'(b); f.r2 = 3'(a); f.st = 1'b1;
    end else if (b != 7) begin
      f.r1 = 3'(a); f.imm = 3'(b); f.br = 1'b1;
    end
    f.we = op < 6 && a != 0;
    return f;
  endfunction

  // Model: where the stage is in its fetch/issue cycle, the PC and the held instruction
  bit m_fetch = 1'b1, m_wait = 1'b0, m_hold = 1'b0, m_halt = 1'b0, m_flush = 1'b0;
  int m_pc = 0;
  logic [8:0] m_instr = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fetch = 1'b1; m_wait = 1'b0; m_hold = 1'b0; m_halt = 1'b0; m_flush = 1'b0; m_pc = 0;
    end else if (!m_halt) begin
      if (branch_taken) begin
        if (m_wait) m_flush = m_flush || !imem_ack;
        else if (imem_ack) m_flush = 1'b0;
        m_pc = int'(branch_target);
        m_fetch = 1'b1; m_wait = 1'b0; m_hold = 1'b0;
      end else begin
        if (m_wait && imem_ack && !m_flush) begin
          m_instr = imem_data;
          m_pc = (m_pc + 1) % 256;
          m_wait = 1'b0; m_hold = 1'b1;
        end else if (m_fetch) begin
          m_fetch = 1'b0; m_wait = 1'b1;
        end else if (m_hold && !stall) begin
          m_hold = 1'b0;
          if ((m_instr >> 6) == 7 && (m_instr & 9'h7) == 7) m_halt = 1'b1;
          else m_fetch = 1'b1;
        end
        if (imem_ack) m_flush = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    fields_t act, exp;
    exp = m_hold ? ref_decode(m_instr) : '0;
    act = {reg1, reg2, reg_write, reg_we, alu_op, imm, is_load, is_store, is_branch};
    chk("m_fields", 32'(act), 32'(exp));
    chk("m_dec_valid", 32'(dec_valid), 32'(m_hold));
    chk("m_imem_req", 32'(imem_req), 32'(reset && m_fetch));
    chk("m_halted", 32'(halted), 32'(m_halt));
    chk("m_imem_addr", 32'(imem_addr), m_pc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [8:0] w);
    tick();
    imem_ack = 1'b1;
    imem_data = w;
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 1);
    // ADD r1,r2 with a one-cycle memory
    do_fetch(9'b000_001_010);
    chk("add_valid", 32'(dec_valid), 1);
    chk("add_rw", 32'(reg_write), 1);
    chk("add_r1", 32'(reg1), 1);
    chk("add_r2", 32'(reg2), 2);
    chk("add_we", 32'(reg_we), 1);
    chk("add_alu", 32'(alu_op), 0);
    chk("add_pc", 32'(imem_addr), 1);
    tick();
    // SUB held under stall for four cycles
    do_fetch(9'b001_010_011);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(dec_valid), 1);
      chk("stall_rw", 32'(reg_write), 2);
      chk("stall_alu", 32'(alu_op), 1);
      tick();
    end
    stall = 1'b0;
    chk("stall_noreq", 32'(imem_req), 0);
    tick();
    chk("after_stall_req", 32'(imem_req), 1);
    // redirect to 0xFF, then wrap on fetch
    branch_taken = 1'b1;
    branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    chk("br_ff_addr", 32'(imem_addr), 32'hFF);
    do_fetch(9'b100_101_110);
    chk("wrap_pc", 32'(imem_addr), 0);
    chk("ldi_rw", 32'(reg_write), 5);
    chk("ldi_imm", 32'(imm), 6);
    chk("ldi_r1", 32'(reg1), 0);
    tick();
    // redirect during WAIT, stale ack discarded
    tick();
    chk("wait_noreq", 32'(imem_req), 0);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    chk("flush_addr", 32'(imem_addr), 32'h40);
    chk("flush_req", 32'(imem_req), 1);
    tick();
    imem_ack = 1'b1;
    imem_data = 9'b000_011_011;
    tick();
    imem_ack = 1'b0;
    chk("stale_novalid", 32'(dec_valid), 0);
    chk("stale_pc", 32'(imem_addr), 32'h40);
    tick();
    imem_ack = 1'b1;
    imem_data = 9'b101_010_100;
    tick();
    imem_ack = 1'b0;
    chk("lw_load", 32'(is_load), 1);
    chk("lw_r1", 32'(reg1), 4);
    chk("lw_pc", 32'(imem_addr), 32'h41);
    // redirect coinciding with accept
    branch_taken = 1'b1;
    branch_target = 8'h20;
    tick();
    branch_taken = 1'b0;
    chk("br_iss_valid", 32'(dec_valid), 0);
    chk("br_iss_addr", 32'(imem_addr), 32'h20);
    do_fetch(9'b110_011_100);
    chk("sw_r1", 32'(reg1), 4);
    chk("sw_r2", 32'(reg2), 3);
    chk("sw_store", 32'(is_store), 1);
    chk("sw_we", 32'(reg_we), 0);
    tick();
    do_fetch(9'b000_000_101);
    chk("add_r0_we", 32'(reg_we), 0);
    chk("add_r0_valid", 32'(dec_valid), 1);
    tick();
    do_fetch(9'b111_010_011);
    chk("brz_br", 32'(is_branch), 1);
    chk("brz_r1", 32'(reg1), 2);
    chk("brz_imm", 32'(imm), 3);
    tick();
    do_fetch(9'b011_001_111);
    chk("xor_alu", 32'(alu_op), 3);
    tick();
    // reset mid-WAIT
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 0);
    chk("midrst_addr", 32'(imem_addr), 0);
    chk("midrst_valid", 32'(dec_valid), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("rerelease_req", 32'(imem_req), 1);
    // HALT ignores redirects and acks
    do_fetch(9'b111_000_111);
    chk("halt_issue_valid", 32'(dec_valid), 1);
    chk("halt_issue_br", 32'(is_branch), 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", 32'(halted), 1);
      chk("halt_req", 32'(imem_req), 0);
      branch_taken = i == 5;
      branch_target = 8'h10;
      imem_ack = i == 8;
      tick();
    end
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    chk("halt_addr", 32'(imem_addr), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
